// File: rtl/div_pkg.sv
// Shared constants for the sequential integer divider: FSM encoding,
// default operand width and the divide-by-zero quotient pattern.
package div_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Quotient reported for a zero divisor; replicated to the instance width.
  localparam logic [DEF_WIDTH-1:0] DIV0_QUO = '1;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: takes magnitudes of signed operands
// and re-applies the sign to quotient/remainder.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? -value : value;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU (quotient -> LO, remainder -> HI).
// Optional SEQ_DIV_EARLY_OUT_EN skips the iteration when |A| < |B|.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             zero_div;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fixed;
  logic [WIDTH-1:0] r_fixed;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_trial;
  logic             accept;
  logic             b_zero;
  logic             skip_calc;

  div_sign_fix #(.WIDTH(WIDTH)) u_a_abs (
    .value (A),
    .neg   (signed_op & A[WIDTH-1]),
    .result(a_mag)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_b_abs (
    .value (B),
    .neg   (signed_op & B[WIDTH-1]),
    .result(b_mag)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_q_sign (
    .value (quo),
    .neg   (sign_q),
    .result(q_fixed)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_r_sign (
    .value (rem),
    .neg   (sign_r),
    .result(r_fixed)
  );

  // busy lags the FSM by one edge, so the done cycle is already back in IDLE;
  // gating on busy keeps a start in that cycle from being accepted.
  assign accept = (state == ST_IDLE) && start && !busy;
  assign b_zero = (B == '0);

`ifdef SEQ_DIV_EARLY_OUT_EN
  assign skip_calc = b_zero || (a_mag < b_mag);
`else
  assign skip_calc = b_zero;
`endif

  // One extra bit so the trial subtraction never truncates.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign rem_trial = rem_shift - {1'b0, dvs};

  // Control and architectural outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      zero_div    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state != ST_IDLE);
      done <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt      <= CNT_W'(WIDTH);
            zero_div <= b_zero;
            state    <= skip_calc ? ST_FIX : ST_CALC;
          end
        end
        ST_CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          quotient    <= zero_div ? {WIDTH{DIV0_QUO[0]}} : q_fixed;
          remainder   <= r_fixed;
          div_by_zero <= zero_div;
          state       <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: shortcut paths preload rem with |A| so the sign fix returns A.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvs    <= b_mag;
      sign_q <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
      sign_r <= signed_op & A[WIDTH-1];
      if (skip_calc) begin
        rem <= a_mag;
        quo <= '0;
      end else begin
        rem <= '0;
        quo <= a_mag;
      end
    end else if (state == ST_CALC) begin
      if (!rem_trial[WIDTH]) begin
        rem <= rem_trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= rem_shift[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32) with hand-computed expectations.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;
  logic gap;

`ifdef SEQ_DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  seq_divider dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_op  (signed_op),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called just after an edge; returns edges from accept to done in lat.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    A = a; B = b; signed_op = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 32'hDEAD_BEEF; B = 32'h0000_0005;
    lat = 0;
    gap = 1'b0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!busy) gap = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quo", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, 1'b0);
    check("u100_lat", 32'(lat), 32'd34);
    check("u100_gap", 32'(gap), 32'd0);
    check("u100_quo", quotient, 32'd14);
    check("u100_rem", remainder, 32'd2);
    check("u100_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #1;
    check("u100_pulse", 32'(done), 32'd0);

    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    check("sm7_quo", quotient, 32'hFFFF_FFFD);
    check("sm7_rem", remainder, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    check("s7m2_quo", quotient, 32'hFFFF_FFFD);
    check("s7m2_rem", remainder, 32'd1);
    @(posedge clk); #1;

    run_op(32'h0000_1234, 32'd0, 1'b0);
    check("dbz_lat", 32'(lat), 32'd2);
    check("dbz_gap", 32'(gap), 32'd0);
    check("dbz_quo", quotient, 32'hFFFF_FFFF);
    check("dbz_rem", remainder, 32'h0000_1234);
    check("dbz_flag", 32'(div_by_zero), 32'd1);
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, 1'b0);
    check("dbz_clear", 32'(div_by_zero), 32'd0);
    check("dbz_next_quo", quotient, 32'd14);
    @(posedge clk); #1;

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("ovf_quo", quotient, 32'h8000_0000);
    check("ovf_rem", remainder, 32'd0);
    check("ovf_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #1;

    run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    check("umax_quo", quotient, 32'hFFFF_FFFF);
    check("umax_rem", remainder, 32'd0);
    @(posedge clk); #1;

    run_op(32'd3, 32'd10, 1'b0);
    check("small_lat", 32'(lat), 32'(EARLY_LAT));
    check("small_quo", quotient, 32'd0);
    check("small_rem", remainder, 32'd3);
    @(posedge clk); #1;

    run_op(32'hFFFF_FFFD, 32'd10, 1'b1);
    check("small_s_quo", quotient, 32'd0);
    check("small_s_rem", remainder, 32'hFFFF_FFFD);
    @(posedge clk); #1;

    // Stray starts during the op and in the done cycle must be ignored.
    A = 32'd1000; B = 32'd3; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    A = 32'd9; B = 32'd9;
    lat = 0;
    while (!done && lat < 100) begin
      start = (lat == 5 || lat == 10);
      @(posedge clk); #1;
      lat++;
    end
    check("hs_lat", 32'(lat), 32'd34);
    check("hs_quo", quotient, 32'd333);
    check("hs_rem", remainder, 32'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("hs_done_busy", 32'(busy), 32'd0);
    check("hs_done_pulse", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("hs_no_accept", 32'(busy), 32'd0);
    check("hs_quo_held", quotient, 32'd333);

    // Reset in the middle of CALC, with a start in the same cycle.
    A = 32'd1000; B = 32'd3; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_quo", quotient, 32'd0);
    check("mrst_rem", remainder, 32'd0);
    check("mrst_dbz", 32'(div_by_zero), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mrst_idle", 32'(busy), 32'd0);
    check("mrst_nodone", 32'(done), 32'd0);

    run_op(32'd50, 32'd5, 1'b0);
    check("post_lat", 32'(lat), 32'd34);
    check("post_quo", quotient, 32'd10);
    check("post_rem", remainder, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
